fetch_queue_stage: RTL and testbench
====================================

Name: fetch_queue_stage

Overview:
Parametrised successor to the single-register fetch stage: a PC generator plus a circular instruction queue between the asynchronous-read instruction memory and decode.
- Taken-predicted branches redirect the PC the same cycle using the predictor's target; fetch never idles waiting for execute to resolve the branch.
- Decode consumes entries with a valid/ready handshake; a data-hazard stall is expressed by deasserting out_ready.
- Execute-stage mispredict redirect flushes the queue.

Parameters:
PC_WIDTH, 32, width of PC and targets
INST_WIDTH, 32, instruction width
QUEUE_DEPTH, 4, queue entries (power of two, ≥2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous and active-high
imem_addr  out  PC_WIDTH  fetch address (= pc register)
imem_rdata  in  INST_WIDTH  instruction at imem_addr, combinational
pred_taken  in  1  predictor taken for imem_addr
pred_target  in  PC_WIDTH  predicted target for imem_addr
redirect_valid  in  1  mispredict/irregular PC from execute
redirect_pc  in  PC_WIDTH  correct next PC
out_valid  out  1  queue head valid
out_ready  in  1  decode accepts head (0 = data hazard stall)
out_pc  out  PC_WIDTH  head PC
out_inst  out  INST_WIDTH  head instruction
out_pred_taken  out  1  head was predicted taken

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC; queue empty (rd_ptr=wr_ptr=0, count=0); out_valid=0.
- Reset has priority over every other event.
- is_ctrl = imem_rdata[6:0] ∈ {1100011, 1100111, 1101111}. pred_taken is ignored when is_ctrl=0.
- push = !rst & !redirect_valid & (count<QUEUE_DEPTH).
  - Full is decided from the registered count; no push on a full-queue cycle even if a pop occurs.
- pop = out_valid & out_ready & !redirect_valid.
- On push:
  - Write {pc, imem_rdata, is_ctrl&pred_taken} at wr_ptr; wr_ptr += 1 (mod QUEUE_DEPTH).
  - pc <= (is_ctrl & pred_taken) ? {pred_target[PC_WIDTH-1:2], 2'b00} : pc+4.
- No push and no redirect: pc holds.
- Pop advances rd_ptr (mod QUEUE_DEPTH). count += push - pop; push and pop in the same cycle leave count unchanged.
- Redirect (redirect_valid=1):
  - Queue flushed: count=0, rd_ptr=wr_ptr=0.
  - pc <= {redirect_pc[PC_WIDTH-1:2], 2'b00}.
  - No push or pop that cycle; out_valid forced 0 combinationally in that cycle.
  - The first post-redirect instruction appears at out one cycle later.
- Latency: an instruction fetched in cycle t is at the head no earlier than cycle t+1.
- out_* reflect the head entry combinationally. out_valid = (count≠0) & !redirect_valid.
- out_pc/out_inst/out_pred_taken are don't-care when out_valid=0.
- PC arithmetic wraps modulo 2^PC_WIDTH.
- Stall: out_ready=0 holds the head stable (contents and valid) until accepted. Fetch continues until the queue is full.
- Throughput: one instruction per cycle sustained when out_ready=1.

Optional Feature:
FETCH_PERF_COUNTERS_EN
- Defined: adds outputs perf_fetched, perf_flushed and perf_full_cycles, each 32 bits, reset to 0, saturating at all-ones.
  - perf_fetched increments on push.
  - perf_flushed adds the count discarded at a redirect.
  - perf_full_cycles increments each cycle count==QUEUE_DEPTH.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then straight-line code, out_ready=1 → out_pc 0x0, 0x4, 0x8… one per cycle from cycle 2; out_valid=0 in cycle 1.
- BEQ at 0x10, pred_taken=1, pred_target=0x40 → entry 0x10 with out_pred_taken=1; next entry pc 0x40, no bubble.
- out_ready=0 for 10 cycles, QUEUE_DEPTH=4 → after 4 pushes imem_addr holds at 0x10; head stays 0x0. Release → 0x0, 0x4, 0x8, 0xC, 0x10 consecutive.
- Queue holds 3 entries, redirect_valid=1 with redirect_pc=0x103 → out_valid=0 that cycle; next cycle out_pc=0x100; flushed entries never appear.
- redirect_valid and out_ready both 1 with full queue → no pop is counted and no push; the queue is empty afterwards.
- rst asserted mid-stall with queue full → next cycle out_valid=0 and imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_queue_stage_if.sv
// Fetch-queue stage bus: instruction memory port, branch predictor lookup,
// execute-stage redirect and the decode-side valid/ready handshake.
// The master modport is the fetch stage itself; slave is its environment.
interface fetch_queue_stage_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic                  pred_taken;
    logic [PC_WIDTH-1:0]   pred_target;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [PC_WIDTH-1:0]   out_pc;
    logic [INST_WIDTH-1:0] out_inst;
    logic                  out_pred_taken;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  pred_taken,
        input  pred_target,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_inst,
        output out_pred_taken
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output pred_taken,
        output pred_target,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_inst,
        input  out_pred_taken
    );
endinterface

// File: rtl/fetch_queue_stage.sv
// Fetch stage: PC generator feeding a circular instruction queue that sits
// between an asynchronous-read instruction memory and decode. Predicted-taken
// control transfers redirect the PC in the same cycle; an execute redirect
// flushes the queue. Optional macro FETCH_PERF_COUNTERS_EN adds saturating
// fetched / flushed / full-cycle counters.
module fetch_queue_stage #(
    parameter int unsigned          PC_WIDTH    = 32,
    parameter int unsigned          INST_WIDTH  = 32,
    parameter int unsigned          QUEUE_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    fetch_queue_stage_if.master        bus
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    output logic [31:0]                perf_fetched,
    output logic [31:0]                perf_flushed,
    output logic [31:0]                perf_full_cycles
`endif
);

    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

    // Control state
    logic [PC_WIDTH-1:0] pc_q,     pc_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]    count_q,  count_d;

    // Queue storage (data only, never reset: pointers/count define validity)
    logic [PC_WIDTH-1:0]   pc_mem_q   [QUEUE_DEPTH];
    logic [INST_WIDTH-1:0] inst_mem_q [QUEUE_DEPTH];
    logic                  pt_mem_q   [QUEUE_DEPTH];

    logic                is_ctrl;
    logic                taken;
    logic                full;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] tgt_pc;
    logic [PC_WIDTH-1:0] redir_pc;

    // Low bits of the target buses are discarded by word alignment.
    logic unused_bits;
    assign unused_bits = ^{bus.pred_target[1:0], bus.redirect_pc[1:0]};

    // Decode the opcode to see whether the predictor's opinion applies
    always_comb begin
        is_ctrl = 1'b0;
        unique case (bus.imem_rdata[6:0])
            7'b1100011,
            7'b1100111,
            7'b1101111: is_ctrl = 1'b1;
            default:    is_ctrl = 1'b0;
        endcase
    end

    assign taken    = is_ctrl & bus.pred_taken;
    assign full     = (count_q == DEPTH_C);
    assign push     = !rst & !bus.redirect_valid & !full;
    assign pop      = bus.out_valid & bus.out_ready & !bus.redirect_valid;
    assign seq_pc   = pc_q + PC_WIDTH'(4);
    assign tgt_pc   = {bus.pred_target[PC_WIDTH-1:2], 2'b00};
    assign redir_pc = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Head of queue drives decode directly; a redirect hides it this cycle
    always_comb begin
        bus.imem_addr      = pc_q;
        bus.out_valid      = (count_q != '0) & !bus.redirect_valid;
        bus.out_pc         = pc_mem_q[rd_ptr_q];
        bus.out_inst       = inst_mem_q[rd_ptr_q];
        bus.out_pred_taken = pt_mem_q[rd_ptr_q];
    end

    // Next-state for PC, pointers and occupancy
    always_comb begin
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.redirect_valid) begin
            pc_d     = redir_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = taken ? tgt_pc : seq_pc;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Write the fetched entry into the slot at the write pointer
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= pc_q;
            inst_mem_q[wr_ptr_q] <= bus.imem_rdata;
            pt_mem_q[wr_ptr_q]   <= taken;
        end
    end

`ifdef FETCH_PERF_COUNTERS_EN
    // Saturating 32-bit accumulate
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] perf_fetched_q,     perf_fetched_d;
    logic [31:0] perf_flushed_q,     perf_flushed_d;
    logic [31:0] perf_full_cycles_q, perf_full_cycles_d;

    // Counter next-state: flushed accumulates the occupancy thrown away
    always_comb begin
        perf_fetched_d     = perf_fetched_q;
        perf_flushed_d     = perf_flushed_q;
        perf_full_cycles_d = perf_full_cycles_q;
        if (push) begin
            perf_fetched_d = sat_add(perf_fetched_q, 32'd1);
        end
        if (bus.redirect_valid) begin
            perf_flushed_d = sat_add(perf_flushed_q, 32'(count_q));
        end
        if (full) begin
            perf_full_cycles_d = sat_add(perf_full_cycles_q, 32'd1);
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q     <= '0;
            perf_flushed_q     <= '0;
            perf_full_cycles_q <= '0;
        end else begin
            perf_fetched_q     <= perf_fetched_d;
            perf_flushed_q     <= perf_flushed_d;
            perf_full_cycles_q <= perf_full_cycles_d;
        end
    end

    assign perf_fetched     = perf_fetched_q;
    assign perf_flushed     = perf_flushed_q;
    assign perf_full_cycles = perf_full_cycles_q;
`endif

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed testbench for fetch_queue_stage (default depth 4, RESET_PC 0).
module tb_fetch_queue_stage;

    localparam logic [31:0] BEQ_INST = 32'h00A50863;

    logic clk;
    logic rst;
    logic br_en;
    int   checks;
    int   errors;

    fetch_queue_stage_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus ();

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
    logic [31:0] perf_full_cycles;
`endif

    fetch_queue_stage #(
        .PC_WIDTH(32),
        .INST_WIDTH(32),
        .QUEUE_DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FETCH_PERF_COUNTERS_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_full_cycles(perf_full_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: a BEQ at 0x10 when enabled, otherwise ADDI-style words
    function automatic logic [31:0] exp_inst(input logic [31:0] a, input logic br);
        if (br && a == 32'h10) return BEQ_INST;
        return {a[24:0], 7'b0010011};
    endfunction

    always_comb bus.imem_rdata = exp_inst(bus.imem_addr, br_en);

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b1;
        do_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if (bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc: got %h expected 00000000", bus.imem_addr);
        end
    endtask

    task automatic test_straight_line();
        logic [31:0] e;
        for (int i = 0; i < 6; i++) begin
            tick();
            e = 32'(i * 4);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== e) begin
                errors++;
                $display("FAIL straight_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, bus.out_valid, bus.out_pc, e);
            end
            checks++;
            if (bus.out_inst !== exp_inst(e, 1'b0) || bus.out_pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL straight_inst[%0d]: got %h/%b expected %h/0", i, bus.out_inst, bus.out_pred_taken, exp_inst(e, 1'b0));
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] pcs [8];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h40, 32'h44, 32'h48};
        br_en = 1'b1;
        bus.pred_taken  = 1'b1;
        bus.pred_target = 32'h42;
        bus.out_ready   = 1'b1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== pcs[i]) begin
                errors++;
                $display("FAIL branch_pc[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, bus.out_valid, bus.out_pc, pcs[i]);
            end
            checks++;
            if (bus.out_pred_taken !== (pcs[i] == 32'h10) || bus.out_inst !== exp_inst(pcs[i], 1'b1)) begin
                errors++;
                $display("FAIL branch_pt[%0d]: got pt=%b inst=%h expected pt=%b inst=%h", i, bus.out_pred_taken, bus.out_inst, (pcs[i] == 32'h10), exp_inst(pcs[i], 1'b1));
            end
        end
        br_en = 1'b0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = 32'h0;
    endtask

    task automatic test_stall();
        logic [31:0] pcs [5];
        pcs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        bus.out_ready = 1'b0;
        do_reset();
        repeat (10) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
                errors++;
                $display("FAIL stall_head: got v=%b pc=%h expected v=1 pc=00000000", bus.out_valid, bus.out_pc);
            end
        end
        checks++;
        if (bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL stall_pc_hold: got %h expected 00000010", bus.imem_addr);
        end
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== pcs[i]) begin
                errors++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h expected v=1 pc=%h", i, bus.out_valid, bus.out_pc, pcs[i]);
            end
            tick();
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        do_reset();
        repeat (3) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_pre: got v=%b pc=%h expected v=1 pc=00000000", bus.out_valid, bus.out_pc);
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_valid_now: got %b expected 0", bus.out_valid);
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h100) begin
            errors++;
            $display("FAIL flush_after: got v=%b addr=%h expected v=0 addr=00000100", bus.out_valid, bus.imem_addr);
        end
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin
            errors++;
            $display("FAIL flush_first: got v=%b pc=%h expected v=1 pc=00000100", bus.out_valid, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h104) begin
            errors++;
            $display("FAIL flush_second: got v=%b pc=%h expected v=1 pc=00000104", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_redirect_full();
        bus.out_ready = 1'b0;
        do_reset();
        repeat (4) tick();
        checks++;
        if (bus.imem_addr !== 32'h10 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL rfull_pre: got addr=%h pc=%h expected addr=00000010 pc=00000000", bus.imem_addr, bus.out_pc);
        end
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rfull_valid_now: got %b expected 0", bus.out_valid);
        end
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h200) begin
            errors++;
            $display("FAIL rfull_empty: got v=%b addr=%h expected v=0 addr=00000200", bus.out_valid, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h200) begin
            errors++;
            $display("FAIL rfull_first: got v=%b pc=%h expected v=1 pc=00000200", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_pc_wrap();
        bus.out_ready = 1'b1;
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFF;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_align: got %h expected fffffffc", bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_head0: got v=%b pc=%h expected v=1 pc=fffffffc", bus.out_valid, bus.out_pc);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_head1: got v=%b pc=%h expected v=1 pc=00000000", bus.out_valid, bus.out_pc);
        end
    endtask

    task automatic test_reset_mid_stall();
        bus.out_ready = 1'b0;
        do_reset();
        repeat (6) tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL rst_stall_pre: got v=%b addr=%h expected v=1 addr=00000010", bus.out_valid, bus.imem_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_stall_post: got v=%b addr=%h expected v=0 addr=00000000", bus.out_valid, bus.imem_addr);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
            errors++;
            $display("FAIL rst_stall_refill: got v=%b pc=%h expected v=1 pc=00000000", bus.out_valid, bus.out_pc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        br_en  = 1'b0;
        bus.pred_taken     = 1'b0;
        bus.pred_target    = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b0;
        @(negedge clk);
        test_reset();
        test_straight_line();
        test_branch();
        test_stall();
        test_flush();
        test_redirect_full();
        test_pc_wrap();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
